// File: rtl/frogger_pkg.sv
// Shared types and constants for the Frogger player-side logic.
package frogger_pkg;

  localparam int         GRID_W  = 8;
  localparam int         GRID_H  = 8;
  localparam logic [2:0] TOP_ROW = 3'd7;

  // Controller states.
  typedef enum logic [1:0] {
    PLAY,
    HOLD,
    RESPAWN,
    OVER
  } state_t;

  // Decoded move event after priority selection.
  typedef enum logic [2:0] {
    NONE,
    UP,
    DOWN,
    LEFT,
    RIGHT
  } move_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frog_mover_if.sv
// Link between the frog controller and the score counter.
//
// Handshake: there is no back-pressure. `up` is a single-cycle strobe that
// the counter must take in the cycle it is high; `finalRow` is qualified by
// `up` (it still shows the pre-move column when the frog leaves row 7).
// `resetEverything` is a single-cycle restart strobe from the counter.
interface frog_mover_if;
  import frogger_pkg::*;

  logic              up;
  logic [GRID_W-1:0] finalRow;
  logic              resetEverything;

  modport master (output up, output finalRow, input resetEverything);
  modport slave  (input up, input finalRow, output resetEverything);

endinterface

// File: rtl/key_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one button.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic evt
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronize the raw button and emit a one-cycle pulse per rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      evt   <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
      evt   <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/frog_mover.sv
// Frog position, lives and respawn controller; drives the counter's up/finalRow.
module frog_mover
  import frogger_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int RESPAWN_CYCLES = 8,
  parameter int LIVES          = 3,
  parameter int START_COL      = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_up,
  input  logic                       key_down,
  input  logic                       key_left,
  input  logic                       key_right,
  input  logic                       collision,
  frog_mover_if.master               score,
  output logic [$clog2(GRID_H)-1:0]  frog_row,
  output logic [GRID_W-1:0]          frog_col,
  output logic                       frog_visible,
  output logic [2:0]                 lives_left,
  output logic                       game_over,
  output state_t                     state_dbg
);

  localparam int                CNT_W     = $clog2(max_int(HOLD_CYCLES, RESPAWN_CYCLES) + 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RESP_LAST = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [2:0]        LIVES_INI = 3'(LIVES);
  localparam logic [GRID_W-1:0] START_OH  = {{(GRID_W-1){1'b0}}, 1'b1} << START_COL;

  logic ev_up, ev_down, ev_left, ev_right;

  key_edge u_key_up    (.clk(clk), .reset(reset), .key(key_up),    .evt(ev_up));
  key_edge u_key_down  (.clk(clk), .reset(reset), .key(key_down),  .evt(ev_down));
  key_edge u_key_left  (.clk(clk), .reset(reset), .key(key_left),  .evt(ev_left));
  key_edge u_key_right (.clk(clk), .reset(reset), .key(key_right), .evt(ev_right));

  move_t             move;
  state_t            state, state_n;
  logic [2:0]        row, row_n;
  logic [GRID_W-1:0] col, col_n;
  logic [2:0]        lives, lives_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              up_c;
  logic              hit;

  // Pick one event per cycle: up beats down beats left beats right.
  always_comb begin
    move = NONE;
    if (ev_up)         move = UP;
    else if (ev_down)  move = DOWN;
    else if (ev_left)  move = LEFT;
    else if (ev_right) move = RIGHT;
  end

  // Collisions only count while the frog is live on the grid.
  assign hit = collision && ((state == PLAY) || (state == HOLD));

  // State, position, lives and hold/respawn counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PLAY;
      row   <= 3'd0;
      col   <= START_OH;
      lives <= LIVES_INI;
      cnt   <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      lives <= lives_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: restart, then collision, then per-state behaviour.
  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    lives_n = lives;
    cnt_n   = cnt;
    up_c    = 1'b0;
    if (score.resetEverything) begin
      state_n = PLAY;
      row_n   = 3'd0;
      col_n   = START_OH;
      lives_n = LIVES_INI;
      cnt_n   = '0;
    end else if (hit) begin
      lives_n = lives - 3'd1;
      row_n   = 3'd0;
      col_n   = START_OH;
      cnt_n   = '0;
      state_n = (lives == 3'd1) ? OVER : RESPAWN;
    end else begin
      case (state)
        PLAY: begin
          case (move)
            UP: begin
              up_c    = 1'b1;
              state_n = HOLD;
              cnt_n   = '0;
              if (row == TOP_ROW) begin
                row_n = 3'd0;
                col_n = START_OH;
              end else begin
                row_n = row + 3'd1;
              end
            end
            DOWN: begin
              if (row != 3'd0) begin
                row_n   = row - 3'd1;
                state_n = HOLD;
                cnt_n   = '0;
              end
            end
            LEFT: begin
              if (!col[0]) begin
                col_n   = col >> 1;
                state_n = HOLD;
                cnt_n   = '0;
              end
            end
            RIGHT: begin
              if (!col[GRID_W-1]) begin
                col_n   = col << 1;
                state_n = HOLD;
                cnt_n   = '0;
              end
            end
            default: ;
          endcase
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_n = PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        RESPAWN: begin
          if (cnt == RESP_LAST) begin
            state_n = PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        OVER: ;
        default: state_n = PLAY;
      endcase
    end
  end

  assign score.up       = up_c;
  assign score.finalRow = (row == TOP_ROW) ? col : '0;
  assign frog_row       = row;
  assign frog_col       = col;
  assign frog_visible   = (state != RESPAWN) && (state != OVER);
  assign lives_left     = lives;
  assign game_over      = (state == OVER);
  assign state_dbg      = state;

endmodule
